// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment constants, decode helpers and tracker states
// Purpose : segment patterns (abcdefg, active-high, bit6 = a), seg_to_bcd decode,
//           ID nibble selection and tracker state encoding.
// Ports   : none (package).
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic {
    ST_HUNT  = 1'b0,
    ST_TRACK = 1'b1
  } trk_state_t;

  // Returns {valid, bcd}; valid is 0 for blank and for any non-digit pattern.
  function automatic logic [4:0] seg_to_bcd(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      SEG_0:   r = {1'b1, 4'd0};
      SEG_1:   r = {1'b1, 4'd1};
      SEG_2:   r = {1'b1, 4'd2};
      SEG_3:   r = {1'b1, 4'd3};
      SEG_4:   r = {1'b1, 4'd4};
      SEG_5:   r = {1'b1, 4'd5};
      SEG_6:   r = {1'b1, 4'd6};
      SEG_7:   r = {1'b1, 4'd7};
      SEG_8:   r = {1'b1, 4'd8};
      SEG_9:   r = {1'b1, 4'd9};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  // Nibble idx of the ID, counting from the first digit in [31:28].
  function automatic logic [3:0] id_nibble(input logic [31:0] id, input logic [2:0] idx);
    logic [31:0] sh;
    sh = id << {idx, 2'b00};
    return sh[31:28];
  endfunction

endpackage

// File: rtl/seg7_id_decoder_if.sv
// rtl/seg7_id_decoder_if.sv - segment input and decoded-ID output bundle
// Purpose : groups the pattern input and all decoder outputs.
// Ports   : seg_in (7), digit (4), digit_valid, bad_seg, match_idx (3), frame_ok, locked.
//           master = pattern source / observer, slave = decoder.
interface seg7_id_decoder_if;
  logic [6:0] seg_in;
  logic [3:0] digit;
  logic       digit_valid;
  logic       bad_seg;
  logic [2:0] match_idx;
  logic       frame_ok;
  logic       locked;

  modport master (
    output seg_in,
    input  digit, digit_valid, bad_seg, match_idx, frame_ok, locked
  );

  modport slave (
    input  seg_in,
    output digit, digit_valid, bad_seg, match_idx, frame_ok, locked
  );
endinterface

// File: rtl/seg7_stable_filter.sv
// rtl/seg7_stable_filter.sv - synchronizer, debounce counter and new-pattern accept strobe
// Purpose : accepts a pattern once it has held STABLE_CYCLES synchronized cycles
//           and differs from the previously accepted pattern.
// Ports   : clk, rst_n (async low), i_seg (7, async), o_accept (comb strobe),
//           o_pattern (7, synchronized stable value).
module seg7_stable_filter #(
  parameter int STABLE_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] i_seg,
  output logic       o_accept,
  output logic [6:0] o_pattern
);
  import seg7_pkg::*;

  localparam int              CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES);

  logic [6:0]    r_sync1, r_sync2, r_hist, r_last;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          w_changed;

  assign w_changed = (r_sync2 != r_hist);

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_changed)
      w_cnt_next = '0;
    else if (r_cnt != CNT_MAX)
      w_cnt_next = r_cnt + 1'b1;
  end

  // Fires only on the step into saturation, so a held pattern strobes once.
  assign o_accept  = (w_cnt_next == CNT_MAX) && (r_cnt != CNT_MAX) && (r_sync2 != r_last);
  assign o_pattern = r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= SEG_BLANK;
      r_sync2 <= SEG_BLANK;
      r_hist  <= SEG_BLANK;
      r_last  <= SEG_BLANK;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_seg;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      r_cnt   <= w_cnt_next;
      if (o_accept)
        r_last <= r_sync2;
    end
  end
endmodule

// File: rtl/seg7_id_decoder.sv
// rtl/seg7_id_decoder.sv - debounced 7-segment decode and 8-digit ID frame tracker
// Purpose : decodes each newly stable pattern to BCD and tracks it against ID_DIGITS.
// Ports   : clk, rst_n (async low), bus (slave): seg_in in; digit, digit_valid,
//           bad_seg, match_idx, frame_ok, locked out.
module seg7_id_decoder
  import seg7_pkg::*;
#(
  parameter int          STABLE_CYCLES = 25_000_000,
  parameter logic [31:0] ID_DIGITS     = 32'h1903_0419
) (
  input  logic              clk,
  input  logic              rst_n,
  seg7_id_decoder_if.slave  bus
);

  logic       w_accept;
  logic [6:0] w_pattern;
  logic [4:0] w_dec;
  logic [3:0] w_exp, w_first;

  trk_state_t r_state, n_state;
  logic [2:0] r_idx, n_idx;
  logic [3:0] r_digit, n_digit;
  logic       r_dv, n_dv, r_bad, n_bad, r_frame, n_frame, r_locked, n_locked;

  seg7_stable_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_seg     (bus.seg_in),
    .o_accept  (w_accept),
    .o_pattern (w_pattern)
  );

  assign w_dec   = seg_to_bcd(w_pattern);
  assign w_exp   = id_nibble(ID_DIGITS, r_idx);
  assign w_first = id_nibble(ID_DIGITS, 3'd0);

  always_comb begin
    n_state  = r_state;
    n_idx    = r_idx;
    n_digit  = r_digit;
    n_locked = r_locked;
    n_dv     = 1'b0;
    n_bad    = 1'b0;
    n_frame  = 1'b0;
    if (w_accept && (w_pattern != SEG_BLANK)) begin
      if (w_dec[4]) begin
        n_digit = w_dec[3:0];
        n_dv    = 1'b1;
        if (w_dec[3:0] == w_exp) begin
          // 3-bit index wraps 7 -> 0 on a completed frame.
          n_idx   = r_idx + 3'd1;
          n_state = ST_TRACK;
          if (r_idx == 3'd7) begin
            n_frame  = 1'b1;
            n_locked = 1'b1;
          end
        end else begin
          // Single-step restart: the mismatching digit may itself start a frame.
          n_locked = 1'b0;
          if (w_dec[3:0] == w_first) begin
            n_idx   = 3'd1;
            n_state = ST_TRACK;
          end else begin
            n_idx   = 3'd0;
            n_state = ST_HUNT;
          end
        end
      end else begin
        n_bad    = 1'b1;
        n_idx    = 3'd0;
        n_state  = ST_HUNT;
        n_locked = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_HUNT;
      r_idx    <= 3'd0;
      r_digit  <= 4'd0;
      r_dv     <= 1'b0;
      r_bad    <= 1'b0;
      r_frame  <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= n_state;
      r_idx    <= n_idx;
      r_digit  <= n_digit;
      r_dv     <= n_dv;
      r_bad    <= n_bad;
      r_frame  <= n_frame;
      r_locked <= n_locked;
    end
  end

  assign bus.digit       = r_digit;
  assign bus.digit_valid = r_dv;
  assign bus.bad_seg     = r_bad;
  assign bus.match_idx   = r_idx;
  assign bus.frame_ok    = r_frame;
  assign bus.locked      = r_locked;
endmodule
